// File: rtl/bin_bbox_detect_if.sv
// rtl/bin_bbox_detect_if.sv - binary pixel stream in, bounding-box result out
//
// Signals:
//   pre_img_vsync/hsync/valid/data  binary pixel stream with frame/line timing
//   bbox_x_min/x_max/y_min/y_max    bounding box of the last complete frame
//   bbox_pix_cnt                    foreground pixel count of the last frame
//   bbox_found                      count reached the noise-rejection threshold
//   bbox_update                     one-cycle pulse when the result registers load
// Modports: master drives the pixel stream, slave is the detector.
interface bin_bbox_detect_if #(
    parameter int X_WIDTH   = 11,
    parameter int Y_WIDTH   = 10,
    parameter int CNT_WIDTH = 20
);
    logic                 pre_img_vsync;
    logic                 pre_img_hsync;
    logic                 pre_img_valid;
    logic                 pre_img_data;
    logic [X_WIDTH-1:0]   bbox_x_min;
    logic [X_WIDTH-1:0]   bbox_x_max;
    logic [Y_WIDTH-1:0]   bbox_y_min;
    logic [Y_WIDTH-1:0]   bbox_y_max;
    logic [CNT_WIDTH-1:0] bbox_pix_cnt;
    logic                 bbox_found;
    logic                 bbox_update;

    modport master (
        output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        input  bbox_pix_cnt, bbox_found, bbox_update
    );

    modport slave (
        input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
        output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        output bbox_pix_cnt, bbox_found, bbox_update
    );
endinterface

// File: rtl/bin_bbox_detect.sv
// rtl/bin_bbox_detect.sv - per-frame bounding box of foreground pixels in a binary stream
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bin_bbox_detect_if.slave: pixel stream in, bbox result out
// The result registers load once per complete frame, in the cycle after the
// frame-end detect, and hold until the next frame completes.
module bin_bbox_detect #(
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 10,
    parameter int CNT_WIDTH  = 20,
    parameter int MIN_PIXELS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_bbox_detect_if.slave     bus
);
    localparam logic [X_WIDTH-1:0]   X_MAX   = '1;
    localparam logic [Y_WIDTH-1:0]   Y_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 vs_d;
    logic                 hs_d;
    logic [X_WIDTH-1:0]   x_cnt;
    logic [Y_WIDTH-1:0]   y_cnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [X_WIDTH-1:0]   x_min_acc;
    logic [X_WIDTH-1:0]   x_max_acc;
    logic [Y_WIDTH-1:0]   y_min_acc;
    logic [Y_WIDTH-1:0]   y_max_acc;

    logic frame_start;
    logic frame_end;
    logic line_end;
    logic start_ok;
    logic pix_ok;
    logic found;

    assign frame_start = bus.pre_img_vsync & ~vs_d;
    assign frame_end   = ~bus.pre_img_vsync & vs_d;
    assign line_end    = ~bus.pre_img_hsync & hs_d;
    assign pix_ok      = bus.pre_img_valid & bus.pre_img_vsync;
    assign found       = (cnt >= MIN_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = ACTIVE;
                    start_ok  = 1'b1;
                end
            end
            ACTIVE: begin
                if (frame_end) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                // A new frame may begin right after a single low vsync cycle.
                if (frame_start) begin
                    state_nxt = ACTIVE;
                    start_ok  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // vs_d comes out of reset high so that a vsync already high when reset
    // releases is not mistaken for a frame start; that partial frame is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b1;
            hs_d      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            cnt       <= '0;
            x_min_acc <= '0;
            x_max_acc <= '0;
            y_min_acc <= '0;
            y_max_acc <= '0;
        end else begin
            vs_d <= bus.pre_img_vsync;
            hs_d <= bus.pre_img_hsync;
            if (start_ok) begin
                x_cnt     <= '0;
                y_cnt     <= '0;
                cnt       <= '0;
                x_min_acc <= X_MAX;
                x_max_acc <= '0;
                y_min_acc <= Y_MAX;
                y_max_acc <= '0;
            end else if (state == ACTIVE) begin
                if (line_end) begin
                    x_cnt <= '0;
                    if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
                end else if (pix_ok) begin
                    if (bus.pre_img_data) begin
                        if (x_cnt < x_min_acc) x_min_acc <= x_cnt;
                        if (x_cnt > x_max_acc) x_max_acc <= x_cnt;
                        if (y_cnt < y_min_acc) y_min_acc <= y_cnt;
                        if (y_cnt > y_max_acc) y_max_acc <= y_cnt;
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    end
                    if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bbox_x_min   <= '0;
            bus.bbox_x_max   <= '0;
            bus.bbox_y_min   <= '0;
            bus.bbox_y_max   <= '0;
            bus.bbox_pix_cnt <= '0;
            bus.bbox_found   <= 1'b0;
            bus.bbox_update  <= 1'b0;
        end else begin
            bus.bbox_update <= 1'b0;
            if (state == LATCH) begin
                bus.bbox_update  <= 1'b1;
                bus.bbox_pix_cnt <= cnt;
                bus.bbox_found   <= found;
                // A rejected frame reports an empty box rather than noise coordinates.
                bus.bbox_x_min   <= found ? x_min_acc : '0;
                bus.bbox_x_max   <= found ? x_max_acc : '0;
                bus.bbox_y_min   <= found ? y_min_acc : '0;
                bus.bbox_y_max   <= found ? y_max_acc : '0;
            end
        end
    end
endmodule
